// File: rtl/uart_mmio_pkg.sv
// rtl/uart_mmio_pkg.sv - register map, bit indices and FSM state types for the UART MMIO bridge
package uart_mmio_pkg;

   // Register offsets relative to BASE_ADDR
   localparam logic [1:0] OFF_DATA   = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_CTRL   = 2'd2;

   // STATUS bit positions
   localparam int ST_RX_NEMPTY = 0;
   localparam int ST_RX_FULL   = 1;
   localparam int ST_TX_NEMPTY = 2;
   localparam int ST_TX_FULL   = 3;
   localparam int ST_TX_DROP   = 4;
   localparam int ST_IRQ       = 7;

   // CTRL bit positions
   localparam int CT_RX_IE       = 0;
   localparam int CT_TX_EMPTY_IE = 1;
   localparam int CT_CLR_DROP    = 7;

   typedef enum logic [1:0] {
      T_IDLE   = 2'd0,
      T_STROBE = 2'd1,
      T_WAIT   = 2'd2
   } tx_state_t;

   typedef enum logic [1:0] {
      R_IDLE   = 2'd0,
      R_STROBE = 2'd1,
      R_WAIT   = 2'd2
   } rx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - 8-bit synchronous FIFO with combinational head and simultaneous push/pop
module byte_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] head,
   output logic       empty,
   output logic       full
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wptr;
   logic [AW:0] rptr;
   logic        do_pop;
   logic        do_push;

   // The extra pointer bit tells full apart from empty when the indices match
   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   // A push into a full FIFO is still accepted when a pop frees the slot this cycle
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rptr[AW-1:0]];

   // Pointer advance; contents are discarded on reset by rewinding both pointers
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   // Storage write; no reset needed since empty masks stale entries
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/uart_mmio_bridge.sv
// rtl/uart_mmio_bridge.sv - CPU bus responder bridging byte registers to the board UART handshake ports
module uart_mmio_bridge
   import uart_mmio_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR  = 16'hF000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic [15:0] addr,
   input  logic [7:0]  din,
   input  logic        read_en,
   output logic [7:0]  dout,
   output logic        hit,
   output logic [7:0]  txdata,
   output logic        txclk,
   input  logic        txready,
   input  logic [7:0]  rxdata,
   output logic        rxclk,
   input  logic        rxready,
   output logic        irq
);

   logic [15:0] offset;
   logic [1:0]  reg_sel;
   logic        data_rd;
   logic        data_wr;
   logic        ctrl_wr;
   logic        prev_match;

   logic        rx_ie;
   logic        tx_empty_ie;
   logic        tx_drop;

   logic        tx_pop;
   logic [7:0]  tx_head;
   logic        tx_empty;
   logic        tx_full;
   logic        tx_load;

   logic        rx_push;
   logic        rx_pop;
   logic [7:0]  rx_head;
   logic        rx_empty;
   logic        rx_full;

   logic [7:0]  status;

   tx_state_t   tx_state, tx_next;
   rx_state_t   rx_state, rx_next;

   // Modular subtraction keeps the window correct even near the top of the map
   assign offset  = addr - BASE_ADDR;
   assign hit     = (offset < 16'd3);
   assign reg_sel = offset[1:0];

   assign data_rd = hit & read_en  & (reg_sel == OFF_DATA);
   assign data_wr = hit & ~read_en & (reg_sel == OFF_DATA);
   assign ctrl_wr = hit & ~read_en & (reg_sel == OFF_CTRL);
   // Only the first cycle of a held DATA read consumes a byte
   assign rx_pop  = data_rd & ~prev_match;

   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .nrst  (nrst),
      .push  (data_wr),
      .pop   (tx_pop),
      .din   (din),
      .head  (tx_head),
      .empty (tx_empty),
      .full  (tx_full)
   );

   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk   (clk),
      .nrst  (nrst),
      .push  (rx_push),
      .pop   (rx_pop),
      .din   (rxdata),
      .head  (rx_head),
      .empty (rx_empty),
      .full  (rx_full)
   );

   // Remember whether the previous cycle was already a DATA read
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) prev_match <= 1'b0;
      else       prev_match <= data_rd;
   end

   // CTRL enables and the sticky drop flag
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         rx_ie       <= 1'b0;
         tx_empty_ie <= 1'b0;
         tx_drop     <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            rx_ie       <= din[CT_RX_IE];
            tx_empty_ie <= din[CT_TX_EMPTY_IE];
         end
         if (data_wr && tx_full && !tx_pop) tx_drop <= 1'b1;
         else if (ctrl_wr && din[CT_CLR_DROP]) tx_drop <= 1'b0;
      end
   end

   // Level interrupt, registered so it lags its condition by one cycle
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) irq <= 1'b0;
      else       irq <= (rx_ie & ~rx_empty) | (tx_empty_ie & tx_empty);
   end

   // TX state register and the byte presented to the transmitter
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         tx_state <= T_IDLE;
         txdata   <= 8'h00;
      end else begin
         tx_state <= tx_next;
         if (tx_load) txdata <= tx_head;
      end
   end

   // TX handshake: launch on ready, strobe once, wait for ready to fall
   always_comb begin
      tx_next = tx_state;
      txclk   = 1'b0;
      tx_pop  = 1'b0;
      tx_load = 1'b0;
      case (tx_state)
         T_IDLE: begin
            if (!tx_empty && txready) begin
               tx_load = 1'b1;
               tx_next = T_STROBE;
            end
         end
         T_STROBE: begin
            txclk   = 1'b1;
            tx_pop  = 1'b1;
            tx_next = T_WAIT;
         end
         T_WAIT: begin
            if (!txready) tx_next = T_IDLE;
         end
         default: tx_next = T_IDLE;
      endcase
   end

   // RX state register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) rx_state <= R_IDLE;
      else       rx_state <= rx_next;
   end

   // RX handshake: accept only with room in the FIFO so no byte is ever lost
   always_comb begin
      rx_next = rx_state;
      rxclk   = 1'b0;
      rx_push = 1'b0;
      case (rx_state)
         R_IDLE: begin
            if (rxready && !rx_full) rx_next = R_STROBE;
         end
         R_STROBE: begin
            rxclk   = 1'b1;
            rx_push = 1'b1;
            rx_next = R_WAIT;
         end
         R_WAIT: begin
            if (!rxready) rx_next = R_IDLE;
         end
         default: rx_next = R_IDLE;
      endcase
   end

   // STATUS image assembled from live flags
   always_comb begin
      status               = 8'h00;
      status[ST_RX_NEMPTY] = ~rx_empty;
      status[ST_RX_FULL]   = rx_full;
      status[ST_TX_NEMPTY] = ~tx_empty;
      status[ST_TX_FULL]   = tx_full;
      status[ST_TX_DROP]   = tx_drop;
      status[ST_IRQ]       = irq;
   end

   // Read mux; zero whenever the address is outside the register window
   always_comb begin
      dout = 8'h00;
      if (hit) begin
         case (reg_sel)
            OFF_DATA:   dout = rx_empty ? 8'h00 : rx_head;
            OFF_STATUS: dout = status;
            OFF_CTRL:   dout = {6'b000000, tx_empty_ie, rx_ie};
            default:    dout = 8'h00;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// tb/tb_uart_mmio_bridge.sv - self-checking bench with queue-level reference model for uart_mmio_bridge
module tb_uart_mmio_bridge;

   localparam logic [15:0] BASE = 16'hF000;
   localparam int          D    = 4;

   logic        clk     = 1'b0;
   logic        nrst    = 1'b0;
   logic [15:0] addr    = 16'h0000;
   logic [7:0]  din     = 8'h00;
   logic        read_en = 1'b1;
   logic [7:0]  dout;
   logic        hit;
   logic [7:0]  txdata;
   logic        txclk;
   logic        txready = 1'b0;
   logic [7:0]  rxdata  = 8'h00;
   logic        rxclk;
   logic        rxready = 1'b0;
   logic        irq;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   uart_mmio_bridge #(.BASE_ADDR(BASE), .FIFO_DEPTH(D)) dut (
      .clk     (clk),
      .nrst    (nrst),
      .addr    (addr),
      .din     (din),
      .read_en (read_en),
      .dout    (dout),
      .hit     (hit),
      .txdata  (txdata),
      .txclk   (txclk),
      .txready (txready),
      .rxdata  (rxdata),
      .rxclk   (rxclk),
      .rxready (rxready),
      .irq     (irq)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0] m_txq[$];
   logic [7:0] m_rxq[$];
   bit         m_drop = 0, m_rx_ie = 0, m_txe_ie = 0, m_prev_rd = 0, m_irq = 0;
   bit         m_tx_strobe = 0, m_tx_wait = 0, m_rx_strobe = 0, m_rx_wait = 0;
   logic [7:0] m_txdata = 8'h00;

   function automatic int reg_of(input logic [15:0] a);
      for (int k = 0; k < 3; k++)
         if (a == 16'(BASE + 16'(k))) return k;
      return -1;
   endfunction

   always @(posedge clk or negedge nrst) begin : model
      int r, txn, rxn;
      bit rd_data, wr_data, wr_ctrl, txpop, irq_n;
      if (!nrst) begin
         m_txq.delete();
         m_rxq.delete();
         m_drop = 0; m_rx_ie = 0; m_txe_ie = 0; m_prev_rd = 0; m_irq = 0;
         m_tx_strobe = 0; m_tx_wait = 0; m_rx_strobe = 0; m_rx_wait = 0;
         m_txdata = 8'h00;
      end else begin
         r       = reg_of(addr);
         rd_data = (r == 0) && read_en;
         wr_data = (r == 0) && !read_en;
         wr_ctrl = (r == 2) && !read_en;
         txn     = m_txq.size();
         rxn     = m_rxq.size();
         irq_n   = (m_rx_ie && rxn > 0) || (m_txe_ie && txn == 0);
         txpop   = m_tx_strobe;
         // CPU pop of the receive queue, first read cycle only
         if (rd_data && !m_prev_rd && rxn > 0) void'(m_rxq.pop_front());
         // transmit side handshake
         if (m_tx_strobe) begin
            m_tx_strobe = 0; m_tx_wait = 1;
            void'(m_txq.pop_front());
         end else if (m_tx_wait) begin
            if (!txready) m_tx_wait = 0;
         end else if (txn > 0 && txready) begin
            m_tx_strobe = 1; m_txdata = m_txq[0];
         end
         // receive side handshake
         if (m_rx_strobe) begin
            m_rx_strobe = 0; m_rx_wait = 1;
            m_rxq.push_back(rxdata);
         end else if (m_rx_wait) begin
            if (!rxready) m_rx_wait = 0;
         end else if (rxready && rxn < D) begin
            m_rx_strobe = 1;
         end
         // CPU writes
         if (wr_data) begin
            if (txn < D || txpop) m_txq.push_back(din);
            else m_drop = 1;
         end
         if (wr_ctrl) begin
            m_rx_ie  = din[0];
            m_txe_ie = din[1];
            if (din[7]) m_drop = 0;
         end
         m_prev_rd = rd_data;
         m_irq     = irq_n;
      end
   end

   // Compare every cycle, away from the active edge
   always @(negedge clk) begin : cmp
      int r;
      logic [7:0] ed;
      r  = reg_of(addr);
      ed = 8'h00;
      if (r == 0)
         ed = (m_rxq.size() > 0) ? m_rxq[0] : 8'h00;
      else if (r == 1)
         ed = {m_irq, 2'b00, m_drop, (m_txq.size() == D), (m_txq.size() > 0),
               (m_rxq.size() == D), (m_rxq.size() > 0)};
      else if (r == 2)
         ed = {6'b000000, m_txe_ie, m_rx_ie};
      chk("hit", hit, (r >= 0));
      chk("dout", dout, ed);
      chk("txclk", txclk, m_tx_strobe);
      chk("rxclk", rxclk, m_rx_strobe);
      chk("txdata", txdata, m_txdata);
      chk("irq", irq, m_irq);
   end

   // ---------------- stimulus helpers ----------------
   logic [7:0] cap [8];
   int         rx_idx, rx_n;
   bit         rx_cool;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      addr = 16'h0000; read_en = 1'b1; din = 8'h00;
   endtask

   task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
      addr = a; din = d; read_en = 1'b0;
      tick();
      idle_bus();
   endtask

   task automatic cpu_rd(input logic [15:0] a, output logic [7:0] d);
      addr = a; read_en = 1'b1;
      #2;
      d = dout;
      tick();
      idle_bus();
   endtask

   // Acts as the transmitter: drops txready for one cycle after every strobe
   task automatic tx_drain(input int cycles, input bit first_low, output int np);
      bit prev;
      np   = 0;
      prev = first_low;
      for (int i = 0; i < cycles; i++) begin
         txready = prev ? 1'b0 : 1'b1;
         prev    = txclk;
         if (txclk) begin
            if (np < 8) cap[np] = txdata;
            np++;
         end
         tick();
      end
      txready = 1'b1;
   endtask

   // Acts as the receiver: offers bytes 1..6, rxready low for one cycle after each strobe
   task automatic rx_feed(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         if (rxclk) begin
            rx_n++; rx_idx++; rxready = 1'b0; rx_cool = 1;
         end else if (rx_cool) begin
            rx_cool = 0; rxready = 1'b0;
         end else begin
            rxdata  = 8'(rx_idx + 1);
            rxready = (rx_idx < 6);
         end
         tick();
      end
   endtask

   initial begin : main
      logic [7:0] rd;
      int         np, n;
      bit         prev, done;

      // Reset state
      tick();
      chk("rst_txclk", txclk, 1'b0);
      chk("rst_rxclk", rxclk, 1'b0);
      chk("rst_irq", irq, 1'b0);
      chk("rst_txdata", txdata, 8'h00);
      cpu_rd(BASE + 16'd1, rd);
      chk("rst_status", rd, 8'h00);
      nrst = 1'b1;
      tick();

      // TX path
      txready = 1'b1;
      cpu_wr(BASE, 8'h41);
      cpu_wr(BASE, 8'h42);
      tx_drain(20, 1'b0, np);
      chk("tx_pulses", np, 2);
      chk("tx_byte0", cap[0], 8'h41);
      chk("tx_byte1", cap[1], 8'h42);
      cpu_rd(BASE + 16'd1, rd);
      chk("tx_nempty_clear", rd[2], 1'b0);

      // TX overflow with the transmitter stalled
      txready = 1'b0;
      for (int i = 0; i < 5; i++) cpu_wr(BASE, 8'(8'hA0 + i));
      cpu_rd(BASE + 16'd1, rd);
      chk("ovf_status", rd, 8'h1C);
      cpu_wr(BASE + 16'd2, 8'h80);
      cpu_rd(BASE + 16'd1, rd);
      chk("drop_cleared", rd, 8'h0C);

      // Write into a full FIFO during the strobe cycle
      txready = 1'b1;
      done    = 0;
      for (int i = 0; i < 10 && !done; i++) begin
         if (txclk) begin
            chk("sim_strobe_byte", txdata, 8'hA0);
            addr = BASE; din = 8'h99; read_en = 1'b0;
            done = 1;
         end
         tick();
      end
      idle_bus();
      chk("sim_strobe_seen", done, 1'b1);
      cpu_rd(BASE + 16'd1, rd);
      chk("sim_status", rd, 8'h0C);
      tx_drain(30, 1'b1, np);
      chk("sim_pulses", np, 4);
      chk("sim_b1", cap[0], 8'hA1);
      chk("sim_b2", cap[1], 8'hA2);
      chk("sim_b3", cap[2], 8'hA3);
      chk("sim_b4", cap[3], 8'h99);

      // RX path with interrupt
      cpu_wr(BASE + 16'd2, 8'h01);
      rxdata = 8'h5A; rxready = 1'b1;
      n = 0; done = 0;
      for (int i = 0; i < 8; i++) begin
         if (rxclk) begin n++; done = 1; end
         rxready = !done;
         tick();
      end
      chk("rx_pulses", n, 1);
      chk("rx_irq_high", irq, 1'b1);
      addr = BASE; read_en = 1'b1;
      #2;
      chk("rx_read", dout, 8'h5A);
      tick();
      #1;
      chk("rx_hold1", dout, 8'h00);
      tick();
      #1;
      chk("rx_hold2", dout, 8'h00);
      tick();
      idle_bus();
      tick(); tick();
      chk("rx_irq_low", irq, 1'b0);
      cpu_rd(BASE + 16'd1, rd);
      chk("rx_empty", rd[0], 1'b0);

      // RX backpressure
      rx_idx = 0; rx_n = 0; rx_cool = 0;
      rx_feed(40);
      chk("bp_pulses", rx_n, 4);
      cpu_rd(BASE + 16'd1, rd);
      chk("bp_full", rd[1], 1'b1);
      cpu_rd(BASE, rd);
      chk("bp_first", rd, 8'h01);
      rx_feed(12);
      chk("bp_fifth", rx_n, 5);
      rxready = 1'b0;

      // Reset pulse in the middle of a transmit strobe
      txready = 1'b1;
      cpu_wr(BASE, 8'h77);
      done = 0;
      for (int i = 0; i < 6 && !done; i++) begin
         if (txclk) done = 1;
         else tick();
      end
      chk("mid_strobe_seen", done, 1'b1);
      chk("mid_irq_before", irq, 1'b1);
      nrst = 1'b0;
      #1;
      chk("mid_rst_txclk", txclk, 1'b0);
      chk("mid_rst_rxclk", rxclk, 1'b0);
      chk("mid_rst_irq", irq, 1'b0);
      addr = BASE + 16'd1; read_en = 1'b1;
      #1;
      chk("mid_rst_status", dout, 8'h00);
      idle_bus();
      tick();
      nrst = 1'b1;
      tick();

      // Randomised traffic against the model
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 3) != 0) begin
            case ($urandom_range(0, 9))
               0, 1, 2, 3: addr = BASE;
               4, 5:       addr = BASE + 16'd1;
               6:          addr = BASE + 16'd2;
               7:          addr = BASE + 16'd3;
               8:          addr = BASE - 16'd1;
               default:    addr = 16'($urandom);
            endcase
            read_en = 1'($urandom);
            din     = 8'($urandom);
         end
         txready = ($urandom_range(0, 2) != 0);
         rxready = ($urandom_range(0, 2) != 0);
         rxdata  = 8'($urandom);
         nrst    = ($urandom_range(0, 299) != 0);
         tick();
      end
      nrst = 1'b1;
      idle_bus();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
